// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: state encoding, sizing helper and inactive-level pattern for the segment scanner
package seg_scan_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BLANK = 2'd1;
   localparam logic [1:0] SHOW  = 2'd2;
   function automatic int clog2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
   function automatic logic [31:0] inact(input bit active_low);
      return active_low ? '1 : '0;
   endfunction
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: enable, pattern input and multiplexed display outputs
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 2,
   parameter int SEG_WIDTH  = 8
);
   logic                            enable_i;
   logic [NUM_DIGITS*SEG_WIDTH-1:0] seg_in_i;
   logic [SEG_WIDTH-1:0]            seg_out_o;
   logic [NUM_DIGITS-1:0]           dig_en_o;
   logic                            frame_done_o;
   modport master (output enable_i, seg_in_i, input seg_out_o, dig_en_o, frame_done_o);
   modport slave  (input enable_i, seg_in_i, output seg_out_o, dig_en_o, frame_done_o);
endinterface

// File: rtl/scan_timer.sv
// scan_timer: loadable down-counter, tc_o high while the count is zero
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;
   assign tc_o = cnt_q == '0;
   always_comb cnt_d = load_i ? load_val_i : (tc_o ? cnt_q : cnt_q - 1'b1);
   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: frame-latched, blank-gapped time multiplexing of digit patterns onto one segment bus
module seg_scan_driver
   import seg_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 2,
   parameter int SEG_WIDTH    = 8,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit ACTIVE_LOW   = 1
) (
   input logic             clk,
   input logic             reset,
   seg_scan_driver_if.slave bus
);
   localparam int MAXC = SCAN_DIV > BLANK_CYCLES ? SCAN_DIV : BLANK_CYCLES;
   localparam int CW = clog2(MAXC > 2 ? MAXC : 2);
   localparam int IW = clog2(NUM_DIGITS > 2 ? NUM_DIGITS : 2);
   localparam logic [SEG_WIDTH-1:0]  SEG_INACT = SEG_WIDTH'(inact(ACTIVE_LOW));
   localparam logic [NUM_DIGITS-1:0] DIG_INACT = NUM_DIGITS'(inact(ACTIVE_LOW));
   localparam logic [CW-1:0] SCAN_LD  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] START_LD = BLANK_CYCLES == 0 ? SCAN_LD : CW'(BLANK_CYCLES - 1);
   localparam logic [1:0]    START    = BLANK_CYCLES == 0 ? SHOW : BLANK;
   localparam logic [IW-1:0] LAST     = IW'(NUM_DIGITS - 1);
   logic [1:0]                      state_q, state_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [NUM_DIGITS*SEG_WIDTH-1:0] buf_q, buf_d;
   logic [SEG_WIDTH-1:0]            seg_q, seg_d;
   logic [NUM_DIGITS-1:0]           dig_q, dig_d;
   logic                            fd_q, fd_d;
   logic                            ld, tc, last;
   logic [CW-1:0]                   ld_val;
   scan_timer #(.W(CW)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .load_i    (ld),
      .load_val_i(ld_val),
      .tc_o      (tc)
   );
   assign last = idx_q == LAST;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      buf_d   = buf_q;
      fd_d    = 1'b0;
      ld      = 1'b0;
      ld_val  = '0;
      if (!bus.enable_i) begin
         state_d = IDLE;
         ld      = 1'b1;
      end else if (state_q == IDLE) begin
         state_d = START;
         idx_d   = '0;
         buf_d   = bus.seg_in_i;
         ld      = 1'b1;
         ld_val  = START_LD;
      end else if (tc && state_q == BLANK) begin
         state_d = SHOW;
         ld      = 1'b1;
         ld_val  = SCAN_LD;
      end else if (tc) begin
         // end of a digit; the frame boundary re-latches the input and wraps
         state_d = START;
         idx_d   = last ? '0 : idx_q + 1'b1;
         buf_d   = last ? bus.seg_in_i : buf_q;
         fd_d    = last;
         ld      = 1'b1;
         ld_val  = START_LD;
      end
      seg_d = state_d == SHOW ? buf_d[idx_d*SEG_WIDTH +: SEG_WIDTH] ^ SEG_INACT : SEG_INACT;
      dig_d = state_d == SHOW ? (NUM_DIGITS'(1) << idx_d) ^ DIG_INACT : DIG_INACT;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         buf_q   <= '0;
         seg_q   <= SEG_INACT;
         dig_q   <= DIG_INACT;
         fd_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         buf_q   <= buf_d;
         seg_q   <= seg_d;
         dig_q   <= dig_d;
         fd_q    <= fd_d;
      end
   end
   assign bus.seg_out_o    = seg_q;
   assign bus.dig_en_o     = dig_q;
   assign bus.frame_done_o = fd_q;
endmodule
